// File: rtl/irq_encode8.sv
// Edge-triggered 8-line interrupt encoder: pending latch, fixed priority select, ack handshake.
// Optional mask register enabled by defining IRQ_ENC_MASK_EN.
module irq_encode8 #(
    parameter int LOW_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    input  logic       irq_ack,
`ifdef IRQ_ENC_MASK_EN
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
`endif
    output logic       irq_valid,
    output logic [2:0] irq_code,
    output logic [7:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       w_load;
    logic       w_ack_take;
    logic [7:0] r_prev;
    logic [7:0] r_pending;
    logic [7:0] w_edge;
    logic [7:0] w_clear;
    logic [7:0] w_mask;
    logic [7:0] w_eligible;
    logic [2:0] r_code;
    logic [2:0] w_sel;

`ifdef IRQ_ENC_MASK_EN
    logic [7:0] r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= 8'h00;
        end else if (mask_we) begin
            r_mask <= mask_wdata;
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = 8'h00;
`endif

    assign w_edge     = irq_in & ~r_prev;
    assign w_eligible = r_pending & ~w_mask;
    assign w_ack_take = (r_state == S_PRESENT) && irq_ack;

    // One-hot clear of the line being acknowledged.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_clear
            assign w_clear[gi] = w_ack_take && (r_code == 3'(gi));
        end
    endgenerate

    // Scan toward the highest-priority end so the last hit wins.
    always_comb begin
        w_sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (LOW_FIRST != 0) begin
                if (w_eligible[7 - i]) begin
                    w_sel = 3'(7 - i);
                end
            end else begin
                if (w_eligible[i]) begin
                    w_sel = 3'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_eligible != 8'h00) begin
                    w_state_next = S_PRESENT;
                    w_load       = 1'b1;
                end
            end
            S_PRESENT: begin
                if (irq_ack) begin
                    w_state_next = S_RECOVER;
                end
            end
            S_RECOVER: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A fresh edge takes precedence over the ack clear of the same line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= 8'h00;
            r_pending <= 8'h00;
            r_code    <= 3'd0;
        end else begin
            r_prev    <= irq_in;
            r_pending <= (r_pending & ~w_clear) | w_edge;
            if (w_load) begin
                r_code <= w_sel;
            end
        end
    end

    assign irq_valid = (r_state == S_PRESENT);
    assign irq_code  = r_code;
    assign pending   = r_pending;

endmodule

// File: tb/tb_irq_encode8.sv
// Bench for irq_encode8: two instances (low-first and high-first priority) driven in parallel,
// directed vector table, hand sequences for reset/mask corners, randomized run against a model.
module tb_irq_encode8;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_in;
    logic       irq_ack;
`ifdef IRQ_ENC_MASK_EN
    logic       mask_we;
    logic [7:0] mask_wdata;
`endif
    logic       valid_lo, valid_hi;
    logic [2:0] code_lo, code_hi;
    logic [7:0] pend_lo, pend_hi;

    irq_encode8 #(.LOW_FIRST(1)) u_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .irq_ack   (irq_ack),
`ifdef IRQ_ENC_MASK_EN
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
`endif
        .irq_valid (valid_lo),
        .irq_code  (code_lo),
        .pending   (pend_lo)
    );

    irq_encode8 #(.LOW_FIRST(0)) u_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .irq_ack   (irq_ack),
`ifdef IRQ_ENC_MASK_EN
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
`endif
        .irq_valid (valid_hi),
        .irq_code  (code_hi),
        .pending   (pend_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 = low-first instance, 1 = high-first instance.
    // phase: 0 waiting, 1 presenting, 2 one-cycle gap after an ack.
    logic [7:0] m_pend [2];
    logic [2:0] m_code [2];
    int         m_phase[2];
    logic [7:0] m_prev;
    logic [7:0] m_mask;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] pick(input logic [7:0] v, input bit low_first);
        int idx;
        idx = 0;
        if (low_first) begin
            for (int i = 7; i >= 0; i--) if (v[i]) idx = i;
        end else begin
            for (int i = 0; i < 8; i++) if (v[i]) idx = i;
        end
        return 3'(idx);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = 8'h00;
            m_code[k]  = 3'd0;
            m_phase[k] = 0;
        end
        m_prev = 8'h00;
        m_mask = 8'h00;
    endtask

    // Advance model from the current inputs, clock once, compare both instances.
    task automatic step();
        logic [7:0] edges;
        logic [7:0] clr;
        edges = irq_in & ~m_prev;
        for (int k = 0; k < 2; k++) begin
            clr = 8'h00;
            if (m_phase[k] == 1 && irq_ack) clr[m_code[k]] = 1'b1;
            if (m_phase[k] == 0) begin
                if ((m_pend[k] & ~m_mask) != 8'h00) begin
                    m_code[k]  = pick(m_pend[k] & ~m_mask, k == 0);
                    m_phase[k] = 1;
                end
            end else if (m_phase[k] == 1) begin
                if (irq_ack) m_phase[k] = 2;
            end else begin
                m_phase[k] = 0;
            end
            m_pend[k] = (m_pend[k] & ~clr) | edges;
        end
        m_prev = irq_in;
`ifdef IRQ_ENC_MASK_EN
        if (mask_we) m_mask = mask_wdata;
`endif
        @(posedge clk);
        #1;
        check("model_valid_lo", {7'd0, valid_lo}, {7'd0, m_phase[0] == 1});
        check("model_code_lo",  {5'd0, code_lo},  {5'd0, m_code[0]});
        check("model_pend_lo",  pend_lo,          m_pend[0]);
        check("model_valid_hi", {7'd0, valid_hi}, {7'd0, m_phase[1] == 1});
        check("model_code_hi",  {5'd0, code_hi},  {5'd0, m_code[1]});
        check("model_pend_hi",  pend_hi,          m_pend[1]);
    endtask

    task automatic drain();
        irq_in  = 8'h00;
        irq_ack = 1'b1;
        for (int i = 0; i < 24; i++) step();
        irq_ack = 1'b0;
        step();
    endtask

    typedef struct {
        logic [7:0] irq;
        logic       ack;
        logic       v_lo;
        logic [2:0] c_lo;
        logic [7:0] p_lo;
        logic       v_hi;
        logic [2:0] c_hi;
        logic [7:0] p_hi;
    } vec_t;

    vec_t tbl[29];

    initial begin
        // Row: inputs for one cycle, expected outputs in the following cycle.
        tbl[0]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[1]  = '{8'h81, 1'b0, 1'b0, 3'd0, 8'h81, 1'b0, 3'd0, 8'h81};
        tbl[2]  = '{8'h81, 1'b0, 1'b1, 3'd0, 8'h81, 1'b1, 3'd7, 8'h81};
        tbl[3]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h80, 1'b0, 3'd0, 8'h01};
        tbl[4]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0, 3'd0, 8'h01};
        tbl[5]  = '{8'h00, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 3'd0, 8'h01};
        tbl[6]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[7]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[8]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[9]  = '{8'h04, 1'b0, 1'b0, 3'd0, 8'h04, 1'b0, 3'd0, 8'h04};
        tbl[10] = '{8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 3'd2, 8'h04};
        tbl[11] = '{8'h04, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[12] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[13] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[14] = '{8'h20, 1'b0, 1'b0, 3'd0, 8'h20, 1'b0, 3'd0, 8'h20};
        tbl[15] = '{8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 3'd5, 8'h20};
        tbl[16] = '{8'h21, 1'b0, 1'b1, 3'd5, 8'h21, 1'b1, 3'd5, 8'h21};
        tbl[17] = '{8'h21, 1'b1, 1'b0, 3'd0, 8'h01, 1'b0, 3'd0, 8'h01};
        tbl[18] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h01, 1'b0, 3'd0, 8'h01};
        tbl[19] = '{8'h00, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1, 3'd0, 8'h01};
        tbl[20] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[21] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[22] = '{8'h08, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0, 3'd0, 8'h08};
        tbl[23] = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1, 3'd3, 8'h08};
        tbl[24] = '{8'h08, 1'b1, 1'b0, 3'd0, 8'h08, 1'b0, 3'd0, 8'h08};
        tbl[25] = '{8'h08, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0, 3'd0, 8'h08};
        tbl[26] = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1, 3'd3, 8'h08};
        tbl[27] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
        tbl[28] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};

        rst_n   = 1'b0;
        irq_in  = 8'h00;
        irq_ack = 1'b0;
`ifdef IRQ_ENC_MASK_EN
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid_lo", {7'd0, valid_lo}, 8'h00);
        check("reset_code_lo",  {5'd0, code_lo},  8'h00);
        check("reset_pend_lo",  pend_lo,          8'h00);
        check("reset_valid_hi", {7'd0, valid_hi}, 8'h00);
        rst_n = 1'b1;

        // Directed vector table
        for (int r = 0; r < 29; r++) begin
            irq_in  = tbl[r].irq;
            irq_ack = tbl[r].ack;
            step();
            check($sformatf("tbl%0d_valid_lo", r), {7'd0, valid_lo}, {7'd0, tbl[r].v_lo});
            check($sformatf("tbl%0d_pend_lo", r),  pend_lo,          tbl[r].p_lo);
            check($sformatf("tbl%0d_valid_hi", r), {7'd0, valid_hi}, {7'd0, tbl[r].v_hi});
            check($sformatf("tbl%0d_pend_hi", r),  pend_hi,          tbl[r].p_hi);
            if (tbl[r].v_lo) check($sformatf("tbl%0d_code_lo", r), {5'd0, code_lo}, {5'd0, tbl[r].c_lo});
            if (tbl[r].v_hi) check($sformatf("tbl%0d_code_hi", r), {5'd0, code_hi}, {5'd0, tbl[r].c_hi});
            $display("tbl row %0d: irq=%h ack=%0d -> lo v=%0d c=%0d p=%h | hi v=%0d c=%0d p=%h",
                     r, tbl[r].irq, tbl[r].ack, valid_lo, code_lo, pend_lo, valid_hi, code_hi, pend_hi);
        end

        // Reset asserted while presenting, with a line held high across release
        irq_in  = 8'h40;
        irq_ack = 1'b0;
        step();
        step();
        check("pre_abort_valid", {7'd0, valid_lo}, 8'h01);
        check("pre_abort_code",  {5'd0, code_lo},  8'h06);
        irq_in = 8'h10;
        rst_n  = 1'b0;
        #2;
        check("abort_valid_lo", {7'd0, valid_lo}, 8'h00);
        check("abort_pend_lo",  pend_lo,          8'h00);
        check("abort_code_lo",  {5'd0, code_lo},  8'h00);
        check("abort_pend_hi",  pend_hi,          8'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("held_line_pend_lo", pend_lo, 8'h10);
        check("held_line_pend_hi", pend_hi, 8'h10);
        step();
        check("held_line_code", {5'd0, code_lo}, 8'h04);
        $display("reset sequence: pend_lo=%h code_lo=%0d valid_lo=%0d", pend_lo, code_lo, valid_lo);
        drain();

`ifdef IRQ_ENC_MASK_EN
        // Masked line latches as pending but is only presented once unmasked
        mask_we    = 1'b1;
        mask_wdata = 8'h02;
        step();
        mask_we = 1'b0;
        irq_in  = 8'h02;
        step();
        check("mask_pend", pend_lo, 8'h02);
        step();
        step();
        check("mask_blocked_lo", {7'd0, valid_lo}, 8'h00);
        check("mask_blocked_hi", {7'd0, valid_hi}, 8'h00);
        mask_we    = 1'b1;
        mask_wdata = 8'h00;
        step();
        mask_we = 1'b0;
        check("unmask_plus1_valid", {7'd0, valid_lo}, 8'h00);
        step();
        check("unmask_plus2_valid", {7'd0, valid_lo}, 8'h01);
        check("unmask_plus2_code",  {5'd0, code_lo},  8'h01);
        $display("mask sequence: valid=%0d code=%0d pend=%h", valid_lo, code_lo, pend_lo);
        drain();
`endif

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            irq_in  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            irq_ack = 1'($urandom_range(0, 1));
`ifdef IRQ_ENC_MASK_EN
            mask_we    = ($urandom_range(0, 7) == 0);
            mask_wdata = 8'($urandom) & 8'($urandom);
`endif
            step();
            if (i % 50 == 0)
                $display("random cycle %0d: irq=%h ack=%0d lo v=%0d c=%0d p=%h hi v=%0d c=%0d p=%h",
                         i, irq_in, irq_ack, valid_lo, code_lo, pend_lo, valid_hi, code_hi, pend_hi);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_encode8.md
IRQ_ENCODE8 -- requirements
Module: irq_encode8

Interface
REQ-001 Parameter LOW_FIRST, default 1: when 1, index 0 is highest priority; when 0, index 7 is highest.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 irq_in  input  8  interrupt request lines, rising-edge sensitive, synchronous to clk.
REQ-005 irq_ack  input  1  consumer acknowledge of the presented code.
REQ-006 mask_we  input  1  mask register write strobe (IRQ_ENC_MASK_EN builds only).
REQ-007 mask_wdata  input  8  mask value; 1 = line blocked (IRQ_ENC_MASK_EN builds only).
REQ-008 irq_valid  output  1  a code is being presented.
REQ-009 irq_code  output  3  binary index of the presented request.
REQ-010 pending  output  8  registered pending-request vector.

Function
REQ-011 The block SHALL register irq_in into irq_prev each cycle and detect edges as irq_in & ~irq_prev.
REQ-012 A detected edge on bit i SHALL set pending[i] at the next rising edge (edge in cycle n -> pending[i]=1 in cycle n+1).
REQ-013 The FSM SHALL have three states: IDLE, PRESENT, RECOVER.
REQ-014 IDLE -> PRESENT when the eligible vector (pending & ~mask) is nonzero; irq_code SHALL be loaded with the highest-priority eligible index per LOW_FIRST on that transition.
REQ-015 Latency: an edge in cycle n on an otherwise idle block SHALL give irq_valid=1 in cycle n+2.
REQ-016 irq_valid SHALL be 1 exactly in PRESENT; irq_code SHALL hold stable throughout PRESENT regardless of new higher-priority requests or mask writes.
REQ-017 PRESENT with irq_ack=1 -> RECOVER; pending[irq_code] SHALL clear on that same clock edge.
REQ-018 RECOVER SHALL last exactly one cycle with irq_valid=0, then -> IDLE.
REQ-019 irq_ack while not in PRESENT SHALL be ignored.
REQ-020 A new edge on bit i in the cycle its ack clears pending[i] SHALL leave pending[i]=1; set wins.
REQ-021 Repeated edges on a bit already pending SHALL not be counted; pending is one bit per line.
REQ-022 irq_code SHALL retain its last value outside PRESENT; it is meaningful only when irq_valid=1.
REQ-023 Back-to-back service SHALL take at least 3 cycles per code: PRESENT, RECOVER, IDLE.

Reset
REQ-024 While rst_n=0: state=IDLE, irq_valid=0, irq_code=3'd0, pending=8'h00, irq_prev=8'h00, mask=8'h00.
REQ-025 Reset asserted mid-PRESENT SHALL abort the presentation immediately with no ack; all pending requests are lost.
REQ-026 A line held high across reset release SHALL be captured as an edge on the first clock after release, because irq_prev resets to 0.

Configuration
REQ-027 Macro IRQ_ENC_MASK_EN defined: an 8-bit mask register exists and is written from mask_wdata when mask_we=1.
REQ-028 With IRQ_ENC_MASK_EN defined, masked lines SHALL still set pending but never be selected.
REQ-029 With IRQ_ENC_MASK_EN defined, unmasking a pending line SHALL make it eligible in the next IDLE evaluation.
REQ-030 Macro IRQ_ENC_MASK_EN undefined: mask_we and mask_wdata are absent, mask is constant 0, and all lines are eligible.

Verification
REQ-031 Reset, then irq_in 00->04 in cycle 1 -> pending=04 in cycle 2, irq_valid=1 and irq_code=2 in cycle 3.
REQ-032 LOW_FIRST=1, simultaneous edges 0x81 -> code 0 presented; after ack, RECOVER, then code 7 presented; pending ends at 0x00.
REQ-033 LOW_FIRST=0, same stimulus 0x81 -> code 7 presented first, then code 0.
REQ-034 During PRESENT with code 5, new edge on bit 0 -> irq_code stays 5 until ack; code 0 follows after RECOVER.
REQ-035 Ack of code 3 coincident with a new edge on bit 3 -> pending[3] remains 1, and code 3 is re-presented after RECOVER and IDLE.
REQ-036 IRQ_ENC_MASK_EN build: mask=0x02, edge on bit 1 -> pending=0x02, irq_valid stays 0; write mask=0x00 -> code 1 presented 2 cycles later.
